// File: rtl/rom_scan_reader.sv
// Read-side client for a one-clock-latency lookup ROM: scans words 0..NUM_WORDS-1 and reports
// sum, max/min with addresses and word count. Define ROM_SCAN_THRESH_EN to add the above_cnt output.
module rom_scan_reader #(
    parameter int NUM_WORDS = 11,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int SUM_W     = 16,
    parameter int THRESH    = 90
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  sum,
    output logic [DATA_W-1:0] max_val,
    output logic [ADDR_W-1:0] max_addr,
    output logic [DATA_W-1:0] min_val,
    output logic [ADDR_W-1:0] min_addr,
    output logic [8:0]        count
`ifdef ROM_SCAN_THRESH_EN
    ,
    output logic [8:0]        above_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t             state_r;
    logic [ADDR_W-1:0]  rom_addr_r;
    logic               busy_r;
    logic               done_r;
    // req_vld_r marks an address currently presented to the ROM; pipe_vld_r marks its returning data.
    logic               req_vld_r;
    logic               pipe_vld_r;
    logic [ADDR_W-1:0]  pipe_addr_r;

    logic [SUM_W-1:0]   sum_r;
    logic [DATA_W-1:0]  max_val_r;
    logic [ADDR_W-1:0]  max_addr_r;
    logic [DATA_W-1:0]  min_val_r;
    logic [ADDR_W-1:0]  min_addr_r;
    logic [8:0]         count_r;

    logic               accept_s;
    logic [SUM_W-1:0]   sum_nxt_s;
    logic               max_upd_s;
    logic               min_upd_s;

    // Start is only honoured while idle
    always_comb begin
        accept_s = 1'b0;
        if ((state_r == S_IDLE) && start) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Scan sequencer: address generation, busy/done and request-valid tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            rom_addr_r <= {ADDR_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            req_vld_r  <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        rom_addr_r <= {ADDR_W{1'b0}};
                        req_vld_r  <= 1'b1;
                        busy_r     <= 1'b1;
                        // A single-word scan has nothing further to address
                        state_r    <= (NUM_WORDS == 1) ? S_DRAIN : S_RUN;
                    end else begin
                        state_r    <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (rom_addr_r == LAST_ADDR) begin
                        req_vld_r <= 1'b0;
                        state_r   <= S_DRAIN;
                    end else begin
                        rom_addr_r <= rom_addr_r + ADDR_ONE;
                        state_r    <= S_RUN;
                    end
                end
                S_DRAIN: begin
                    req_vld_r <= 1'b0;
                    // Finish once the last requested word has come back and been accumulated
                    if (pipe_vld_r && !req_vld_r) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        state_r <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    req_vld_r <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

    // Delay the request by the ROM's read latency so data lines up with its address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_r  <= 1'b0;
            pipe_addr_r <= {ADDR_W{1'b0}};
        end else begin
            pipe_vld_r  <= req_vld_r;
            pipe_addr_r <= rom_addr_r;
        end
    end

    // Strict compares so that ties keep the earliest address
    always_comb begin
        sum_nxt_s = sum_r + SUM_W'(rom_data);
        if (rom_data > max_val_r) begin
            max_upd_s = 1'b1;
        end else begin
            max_upd_s = 1'b0;
        end
        if (rom_data < min_val_r) begin
            min_upd_s = 1'b1;
        end else begin
            min_upd_s = 1'b0;
        end
    end

    // Result accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r      <= {SUM_W{1'b0}};
            max_val_r  <= {DATA_W{1'b0}};
            max_addr_r <= {ADDR_W{1'b0}};
            min_val_r  <= {DATA_W{1'b1}};
            min_addr_r <= {ADDR_W{1'b0}};
            count_r    <= 9'd0;
        end else if (accept_s) begin
            sum_r      <= {SUM_W{1'b0}};
            max_val_r  <= {DATA_W{1'b0}};
            max_addr_r <= {ADDR_W{1'b0}};
            min_val_r  <= {DATA_W{1'b1}};
            min_addr_r <= {ADDR_W{1'b0}};
            count_r    <= 9'd0;
        end else if (pipe_vld_r) begin
            sum_r   <= sum_nxt_s;
            count_r <= count_r + 9'd1;
            if (max_upd_s) begin
                max_val_r  <= rom_data;
                max_addr_r <= pipe_addr_r;
            end
            if (min_upd_s) begin
                min_val_r  <= rom_data;
                min_addr_r <= pipe_addr_r;
            end
        end
    end

`ifdef ROM_SCAN_THRESH_EN
    localparam logic [DATA_W-1:0] THRESH_V = DATA_W'(THRESH);

    logic [8:0] above_cnt_r;
    logic       above_s;

    // Threshold hit for the word currently returning from the ROM
    always_comb begin
        if (rom_data >= THRESH_V) begin
            above_s = 1'b1;
        end else begin
            above_s = 1'b0;
        end
    end

    // Count of accumulated words at or above the threshold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            above_cnt_r <= 9'd0;
        end else if (accept_s) begin
            above_cnt_r <= 9'd0;
        end else if (pipe_vld_r && above_s) begin
            above_cnt_r <= above_cnt_r + 9'd1;
        end
    end

    assign above_cnt = above_cnt_r;
`endif

    assign rom_addr = rom_addr_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign sum      = sum_r;
    assign max_val  = max_val_r;
    assign max_addr = max_addr_r;
    assign min_val  = min_val_r;
    assign min_addr = min_addr_r;
    assign count    = count_r;

endmodule

// File: tb/tb_rom_scan_reader.sv
// Scoreboard bench for rom_scan_reader: four instances (NUM_WORDS 11, 4, 256, 1), each with a
// behavioural one-clock-latency ROM; expected results come from a reference model of the scan rules.
module tb_rom_scan_reader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_s [4];
    logic [7:0] addr_s [4];
    logic [7:0] rdata_s [4];
    logic       busy_s [4];
    logic       done_s [4];
    logic [15:0] sum_s [4];
    logic [7:0] maxv_s [4];
    logic [7:0] maxa_s [4];
    logic [7:0] minv_s [4];
    logic [7:0] mina_s [4];
    logic [8:0] cnt_s [4];
`ifdef ROM_SCAN_THRESH_EN
    logic [8:0] above_s [4];
`endif
    logic [7:0] rom_mem [4][256];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int k; int n; int pc;
        int sum; int maxv; int maxa; int minv; int mina; int cnt; int above;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        rom_scan_reader #(
            .NUM_WORDS(g == 0 ? 11 : (g == 1 ? 4 : (g == 2 ? 256 : 1)))
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start_s[g]),
            .rom_addr(addr_s[g]), .rom_data(rdata_s[g]),
            .busy(busy_s[g]), .done(done_s[g]), .sum(sum_s[g]),
            .max_val(maxv_s[g]), .max_addr(maxa_s[g]),
            .min_val(minv_s[g]), .min_addr(mina_s[g]), .count(cnt_s[g])
`ifdef ROM_SCAN_THRESH_EN
            , .above_cnt(above_s[g])
`endif
        );
    end

    // Registered-output ROMs, one read clock of latency
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) rdata_s[k] <= rom_mem[k][addr_s[k]];
    end

    function automatic int nw(input int k);
        case (k)
            0: return 11;
            1: return 4;
            2: return 256;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input int k, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (cycle %0d)", nm, k, act, expv, cyc);
        end
    endtask

    // Reference model: fold the ROM image with the scan rules
    function automatic exp_t model(input int k);
        exp_t e;
        e.k = k; e.n = nw(k); e.pc = 0;
        e.sum = 0; e.maxv = 0; e.maxa = 0; e.minv = 255; e.mina = 0; e.cnt = 0; e.above = 0;
        for (int i = 0; i < e.n; i++) begin
            int v = int'(rom_mem[k][i]);
            e.sum = (e.sum + v) % 65536;
            if (v > e.maxv) begin e.maxv = v; e.maxa = i; end
            if (v < e.minv) begin e.minv = v; e.mina = i; end
            if (v >= 90) e.above++;
            e.cnt++;
        end
        return e;
    endfunction

    // Monitor: pops the expected scan on done, checks busy/address in between
    always @(negedge clk) begin
        exp_t e;
        bit mine;
        for (int k = 0; k < 4; k++) begin
            mine = (q.size() > 0) && (q[0].k == k);
            if (done_s[k]) begin
                if (!mine) begin
                    chk("spurious_done", k, 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", k, cyc - e.pc, e.n + 2);
                    chk("busy_at_done", k, int'(busy_s[k]), 0);
                    chk("addr_hold", k, int'(addr_s[k]), e.n - 1);
                    chk("sum", k, int'(sum_s[k]), e.sum);
                    chk("max_val", k, int'(maxv_s[k]), e.maxv);
                    chk("max_addr", k, int'(maxa_s[k]), e.maxa);
                    chk("min_val", k, int'(minv_s[k]), e.minv);
                    chk("min_addr", k, int'(mina_s[k]), e.mina);
                    chk("count", k, int'(cnt_s[k]), e.cnt);
`ifdef ROM_SCAN_THRESH_EN
                    chk("above_cnt", k, int'(above_s[k]), e.above);
`endif
                end
            end else if (mine && cyc > q[0].pc) begin
                if (cyc - q[0].pc > q[0].n + 2) begin
                    chk("done_timeout", k, 0, 1);
                    void'(q.pop_front());
                end else begin
                    chk("busy_high", k, int'(busy_s[k]), 1);
                    chk("rom_addr", k, int'(addr_s[k]),
                        (cyc - q[0].pc - 1 < q[0].n - 1) ? cyc - q[0].pc - 1 : q[0].n - 1);
                end
            end else if (!mine) begin
                chk("busy_idle", k, int'(busy_s[k]), 0);
            end
        end
    end

    task automatic chk_reset(input int k);
        chk("rst_addr", k, int'(addr_s[k]), 0);
        chk("rst_busy", k, int'(busy_s[k]), 0);
        chk("rst_done", k, int'(done_s[k]), 0);
        chk("rst_sum", k, int'(sum_s[k]), 0);
        chk("rst_maxv", k, int'(maxv_s[k]), 0);
        chk("rst_maxa", k, int'(maxa_s[k]), 0);
        chk("rst_minv", k, int'(minv_s[k]), 255);
        chk("rst_mina", k, int'(mina_s[k]), 0);
        chk("rst_cnt", k, int'(cnt_s[k]), 0);
`ifdef ROM_SCAN_THRESH_EN
        chk("rst_above", k, int'(above_s[k]), 0);
`endif
    endtask

    // Raise start and register the expected scan; returns the push cycle
    task automatic issue(input int k, output int pc);
        exp_t e;
        @(negedge clk); #1;
        e = model(k);
        e.pc = cyc;
        pc = cyc;
        q.push_back(e);
        start_s[k] = 1'b1;
        @(negedge clk); #1;
        start_s[k] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            chk("scan_hang", q[0].k, 0, 1);
            q.delete();
        end
        #2;
    endtask

    task automatic scan(input int k);
        int pc;
        issue(k, pc);
        wait_idle();
    endtask

    task automatic load_tv();
        logic [7:0] tv [11] = '{8'd95, 8'd90, 8'd96, 8'd98, 8'd93, 8'd94, 8'd97, 8'd103, 8'd56, 8'd97, 8'd77};
        for (int i = 0; i < 11; i++) rom_mem[0][i] = tv[i];
    endtask

    task automatic chk_tv(input string tag);
        chk({tag, "_sum"}, 0, int'(sum_s[0]), 996);
        chk({tag, "_maxv"}, 0, int'(maxv_s[0]), 103);
        chk({tag, "_maxa"}, 0, int'(maxa_s[0]), 7);
        chk({tag, "_minv"}, 0, int'(minv_s[0]), 56);
        chk({tag, "_mina"}, 0, int'(mina_s[0]), 8);
        chk({tag, "_cnt"}, 0, int'(cnt_s[0]), 11);
`ifdef ROM_SCAN_THRESH_EN
        chk({tag, "_above"}, 0, int'(above_s[0]), 9);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pc;
        for (int k = 0; k < 4; k++) start_s[k] = 1'b0;
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 256; i++) rom_mem[k][i] = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 4; k++) chk_reset(k);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reference vector
        load_tv();
        scan(0);
        chk_tv("tv");

        // Start re-pulsed mid-scan is ignored
        issue(0, pc);
        while (cyc < pc + 5) @(negedge clk);
        #1 start_s[0] = 1'b1;
        @(negedge clk); #1 start_s[0] = 1'b0;
        wait_idle();
        chk_tv("repulse");

        // Start during DONE ignored, start in the following IDLE cycle accepted
        issue(0, pc);
        while (cyc < pc + 13) @(negedge clk);
        #1 start_s[0] = 1'b1;
        begin
            exp_t e;
            @(negedge clk); #1;
            e = model(0);
            e.pc = cyc;
            q.push_back(e);
        end
        @(negedge clk); #1 start_s[0] = 1'b0;
        wait_idle();

        // Reset during cycle 6
        issue(0, pc);
        while (cyc < pc + 6) @(negedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1 chk_reset(0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        scan(0);
        chk_tv("post_rst");

        // Randomized images, including narrow ranges that force ties
        for (int r = 0; r < 8; r++) begin
            int hi = (r % 2 == 0) ? 255 : 3;
            for (int i = 0; i < 11; i++) rom_mem[0][i] = 8'($urandom_range(0, hi));
            for (int i = 0; i < 4; i++) rom_mem[1][i] = 8'($urandom_range(80, 100));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            scan(0);
            scan(1);
        end

        // Ties: all equal words
        for (int i = 0; i < 4; i++) rom_mem[1][i] = 8'd50;
        scan(1);
        chk("tie_sum", 1, int'(sum_s[1]), 200);
        chk("tie_maxa", 1, int'(maxa_s[1]), 0);
        chk("tie_mina", 1, int'(mina_s[1]), 0);
        chk("tie_cnt", 1, int'(cnt_s[1]), 4);

        // Full 256-word scan of 255s
        for (int i = 0; i < 256; i++) rom_mem[2][i] = 8'd255;
        scan(2);
        chk("full_sum", 2, int'(sum_s[2]), 65280);
        chk("full_cnt", 2, int'(cnt_s[2]), 256);

        // Single-word scan
        rom_mem[3][0] = 8'd7;
        scan(3);
        chk("one_sum", 3, int'(sum_s[3]), 7);
        chk("one_maxv", 3, int'(maxv_s[3]), 7);
        chk("one_minv", 3, int'(minv_s[3]), 7);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
